// File: rtl/cell_plotter_if.sv
// Request/pixel bundle between a glyph source and the cell plotter.
// The plotter's pixel outputs are meant to drive the vga stage directly.
interface cell_plotter_if;
    logic        start;
    logic [7:0]  pos_in;
    logic [31:0] bitmap;
    logic [2:0]  fg;
    logic [2:0]  bg;
    logic        transp;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [7:0]  pos;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, pos_in, bitmap, fg, bg, transp,
        input  x, y, pos, colour, plot, busy, done, err
    );

    modport slave (
        input  start, pos_in, bitmap, fg, bg, transp,
        output x, y, pos, colour, plot, busy, done, err
    );
endinterface

// File: rtl/cell_plotter.sv
// Sweeps a 4x8 glyph into one cell position, one registered pixel per clock,
// in row-major order, then pulses done. Out-of-range positions pulse err.
module cell_plotter #(
    parameter int unsigned CELL_W  = 4,
    parameter int unsigned CELL_H  = 8,
    parameter int unsigned MAX_POS = 45
) (
    input logic           clock,
    input logic           reset,
    cell_plotter_if.slave bus
);
    localparam int unsigned NPIX = CELL_W * CELL_H;
    localparam logic [4:0]  LAST = 5'(NPIX - 1);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t      state, state_n;
    logic [4:0]  i, i_n;
    logic [7:0]  pos_l, pos_l_n;
    logic [31:0] bmp_l, bmp_l_n;
    logic [2:0]  fg_l, fg_l_n, bg_l, bg_l_n;
    logic        transp_l, transp_l_n;

    logic [7:0]  x_r, x_n;
    logic [6:0]  y_r, y_n;
    logic [7:0]  pos_r, pos_n;
    logic [2:0]  colour_r, colour_n;
    logic        plot_r, plot_n;
    logic        busy_r, busy_n;
    logic        done_r, done_n;
    logic        err_r, err_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        i_n        = i;
        pos_l_n    = pos_l;
        bmp_l_n    = bmp_l;
        fg_l_n     = fg_l;
        bg_l_n     = bg_l;
        transp_l_n = transp_l;
        x_n        = x_r;
        y_n        = y_r;
        pos_n      = pos_r;
        colour_n   = colour_r;
        plot_n     = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.pos_in < 8'(MAX_POS)) begin
                        pos_l_n    = bus.pos_in;
                        bmp_l_n    = bus.bitmap;
                        fg_l_n     = bus.fg;
                        bg_l_n     = bus.bg;
                        transp_l_n = bus.transp;
                        i_n        = '0;
                        state_n    = DRAW;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            DRAW: begin
                x_n      = 8'(32'(i) % CELL_W);
                y_n      = 7'(32'(i) / CELL_W);
                pos_n    = pos_l;
                colour_n = bmp_l[i] ? fg_l : bg_l;
                plot_n   = bmp_l[i] | ~transp_l;
                // Counter parks on the last pixel so it can never wrap into an extra plot.
                if (i == LAST) state_n = DONE;
                else           i_n     = i + 5'd1;
            end
            DONE: begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            i        <= '0;
            pos_l    <= '0;
            bmp_l    <= '0;
            fg_l     <= '0;
            bg_l     <= '0;
            transp_l <= 1'b0;
            x_r      <= '0;
            y_r      <= '0;
            pos_r    <= '0;
            colour_r <= '0;
            plot_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            i        <= i_n;
            pos_l    <= pos_l_n;
            bmp_l    <= bmp_l_n;
            fg_l     <= fg_l_n;
            bg_l     <= bg_l_n;
            transp_l <= transp_l_n;
            x_r      <= x_n;
            y_r      <= y_n;
            pos_r    <= pos_n;
            colour_r <= colour_n;
            plot_r   <= plot_n;
            busy_r   <= busy_n;
            done_r   <= done_n;
            err_r    <= err_n;
        end
    end

    assign bus.x      = x_r;
    assign bus.y      = y_r;
    assign bus.pos    = pos_r;
    assign bus.colour = colour_r;
    assign bus.plot   = plot_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.err    = err_r;
endmodule

// File: tb/tb_cell_plotter.sv
// Directed bench for cell_plotter: sweep order, colours, transparency,
// rejection, back-to-back starts and reset behaviour.
module tb_cell_plotter;
    logic clock = 1'b0;
    logic reset = 1'b1;

    cell_plotter_if bus ();

    cell_plotter #(.CELL_W(4), .CELL_H(8), .MAX_POS(45)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    logic [26:0] got, exp;

    task automatic issue(input logic [7:0] p, input logic [31:0] b,
                         input logic [2:0] f, input logic [2:0] g, input logic t);
        @(negedge clock);
        bus.start  = 1'b1;
        bus.pos_in = p;
        bus.bitmap = b;
        bus.fg     = f;
        bus.bg     = g;
        bus.transp = t;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_cmp++;
        if ({bus.x, bus.y, bus.pos, bus.colour, bus.plot, bus.busy, bus.done, bus.err} !== 37'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %h required 0",
                     {bus.x, bus.y, bus.pos, bus.colour, bus.plot, bus.busy, bus.done, bus.err});
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_opaque();
        issue(8'd7, 32'hFFFF0000, 3'b100, 3'b001, 1'b0);
        n_cmp++;
        if ({bus.busy, bus.plot, bus.done} !== 3'b100) begin
            n_bad++;
            $display("FAIL opaque_accept: got %b required 100", {bus.busy, bus.plot, bus.done});
        end
        for (int k = 0; k < 32; k++) begin
            @(posedge clock);
            #1;
            got = {bus.x, bus.y, bus.pos, bus.colour, bus.plot};
            exp = {8'(k % 4), 7'(k / 4), 8'd7, (k >= 16) ? 3'b100 : 3'b001, 1'b1};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL opaque_pixel%0d: got %h required %h", k, got, exp);
            end
        end
        @(posedge clock);
        #1;
        n_cmp++;
        if ({bus.done, bus.plot, bus.busy, bus.err} !== 4'b1000) begin
            n_bad++;
            $display("FAIL opaque_done: got %b required 1000", {bus.done, bus.plot, bus.busy, bus.err});
        end
        @(posedge clock);
        #1;
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL opaque_done_pulse: got %b required 0", bus.done);
        end
    endtask

    task automatic test_reject();
        logic [7:0] bad_pos [2] = '{8'd45, 8'd255};
        for (int n = 0; n < 2; n++) begin
            issue(bad_pos[n], 32'hFFFFFFFF, 3'b111, 3'b010, 1'b0);
            n_cmp++;
            if ({bus.err, bus.busy, bus.plot, bus.done, bus.pos} !== {4'b1000, 8'd7}) begin
                n_bad++;
                $display("FAIL reject_err%0d: got %h required %h", n,
                         {bus.err, bus.busy, bus.plot, bus.done, bus.pos}, {4'b1000, 8'd7});
            end
            @(posedge clock);
            #1;
            n_cmp++;
            if ({bus.err, bus.busy, bus.plot, bus.done} !== 4'b0000) begin
                n_bad++;
                $display("FAIL reject_after%0d: got %b required 0000", n,
                         {bus.err, bus.busy, bus.plot, bus.done});
            end
        end
    endtask

    task automatic test_transparent();
        int plots = 0;
        issue(8'd7, 32'hFFFF0000, 3'b100, 3'b001, 1'b1);
        for (int k = 0; k < 32; k++) begin
            @(posedge clock);
            #1;
            if (bus.plot === 1'b1) plots++;
            got = {bus.x, bus.y, bus.pos, bus.colour, bus.plot};
            exp = {8'(k % 4), 7'(k / 4), 8'd7, (k >= 16) ? 3'b100 : 3'b001, (k >= 16) ? 1'b1 : 1'b0};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL transp_pixel%0d: got %h required %h", k, got, exp);
            end
        end
        n_cmp++;
        if (plots != 16) begin
            n_bad++;
            $display("FAIL transp_plot_count: got %0d required 16", plots);
        end
        @(posedge clock);
        #1;
        n_cmp++;
        if ({bus.done, bus.plot} !== 2'b10) begin
            n_bad++;
            $display("FAIL transp_done: got %b required 10", {bus.done, bus.plot});
        end
    endtask

    task automatic test_back_to_back();
        logic seen = 1'b0;
        @(negedge clock);
        bus.start  = 1'b1;
        bus.pos_in = 8'd3;
        bus.bitmap = 32'h000000FF;
        bus.fg     = 3'b010;
        bus.bg     = 3'b101;
        bus.transp = 1'b0;
        @(posedge clock);
        #1;
        bus.pos_in = 8'd9;
        for (int k = 0; k < 32; k++) begin
            @(posedge clock);
            #1;
            got = {bus.x, bus.y, bus.pos, bus.colour, bus.plot};
            exp = {8'(k % 4), 7'(k / 4), 8'd3, (k < 8) ? 3'b010 : 3'b101, 1'b1};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL b2b_pixel%0d: got %h required %h", k, got, exp);
            end
        end
        @(posedge clock);
        #1;
        n_cmp++;
        if ({bus.done, bus.busy, bus.err} !== 3'b100) begin
            n_bad++;
            $display("FAIL b2b_done: got %b required 100", {bus.done, bus.busy, bus.err});
        end
        @(posedge clock);
        #1;
        n_cmp++;
        if ({bus.busy, bus.plot, bus.done} !== 3'b100) begin
            n_bad++;
            $display("FAIL b2b_second_accept: got %b required 100", {bus.busy, bus.plot, bus.done});
        end
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        got = {bus.x, bus.y, bus.pos, bus.colour, bus.plot};
        exp = {8'd0, 7'd0, 8'd9, 3'b010, 1'b1};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL b2b_second_pixel0: got %h required %h", got, exp);
        end
        for (int c = 0; c < 40 && !seen; c++) begin
            @(posedge clock);
            #1;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_second_done: got %b required 1", seen);
        end
    endtask

    task automatic test_reset_mid_draw();
        int spurious = 0;
        issue(8'd20, 32'hAAAAAAAA, 3'b111, 3'b000, 1'b0);
        repeat (9) @(posedge clock);
        #1;
        n_cmp++;
        if (bus.plot !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_pre_plot: got %b required 1", bus.plot);
        end
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.plot, bus.busy, bus.done, bus.x, bus.y, bus.pos} !== 26'd0) begin
            n_bad++;
            $display("FAIL abort_async: got %h required 0",
                     {bus.plot, bus.busy, bus.done, bus.x, bus.y, bus.pos});
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (bus.done === 1'b1 || bus.plot === 1'b1) spurious++;
        end
        n_cmp++;
        if (spurious != 0) begin
            n_bad++;
            $display("FAIL abort_quiet: got %0d required 0", spurious);
        end
        issue(8'd11, 32'h00000001, 3'b110, 3'b001, 1'b0);
        @(posedge clock);
        #1;
        got = {bus.x, bus.y, bus.pos, bus.colour, bus.plot};
        exp = {8'd0, 7'd0, 8'd11, 3'b110, 1'b1};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL abort_restart: got %h required %h", got, exp);
        end
        repeat (40) @(posedge clock);
        #1;
    endtask

    task automatic test_reset_release();
        logic seen = 1'b0;
        @(negedge clock);
        reset      = 1'b1;
        bus.start  = 1'b1;
        bus.pos_in = 8'd5;
        bus.bitmap = 32'h0000000F;
        bus.fg     = 3'b011;
        bus.bg     = 3'b100;
        bus.transp = 1'b0;
        @(posedge clock);
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL release_held: got %b required 0", bus.busy);
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL release_accept: got %b required 1", bus.busy);
        end
        @(posedge clock);
        #1;
        got = {bus.x, bus.y, bus.pos, bus.colour, bus.plot};
        exp = {8'd0, 7'd0, 8'd5, 3'b011, 1'b1};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL release_pixel0: got %h required %h", got, exp);
        end
        for (int c = 0; c < 40 && !seen; c++) begin
            @(posedge clock);
            #1;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b1) begin
            n_bad++;
            $display("FAIL release_done: got %b required 1", seen);
        end
    endtask

    task automatic test_last_pos();
        int plots = 0;
        int late  = 0;
        issue(8'd44, 32'h00000001, 3'b011, 3'b100, 1'b0);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clock);
            #1;
            if (bus.plot === 1'b1) plots++;
            if (c == 1) begin
                got = {bus.x, bus.y, bus.pos, bus.colour, bus.plot};
                exp = {8'd0, 7'd0, 8'd44, 3'b011, 1'b1};
                n_cmp++;
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL last_pos_first: got %h required %h", got, exp);
                end
            end
            if (c == 32) begin
                got = {bus.x, bus.y, bus.pos, bus.colour, bus.plot};
                exp = {8'd3, 7'd7, 8'd44, 3'b100, 1'b1};
                n_cmp++;
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL last_pos_final: got %h required %h", got, exp);
                end
            end
            if (c == 33) begin
                n_cmp++;
                if (bus.done !== 1'b1) begin
                    n_bad++;
                    $display("FAIL last_pos_done: got %b required 1", bus.done);
                end
            end
            if (c > 33 && {bus.plot, bus.x, bus.y, bus.busy} !== {1'b0, 8'd3, 7'd7, 1'b0}) late++;
        end
        n_cmp++;
        if (plots != 32) begin
            n_bad++;
            $display("FAIL last_pos_plot_count: got %0d required 32", plots);
        end
        n_cmp++;
        if (late != 0) begin
            n_bad++;
            $display("FAIL last_pos_hold: got %0d bad idle cycles required 0", late);
        end
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.pos_in = '0;
        bus.bitmap = '0;
        bus.fg     = '0;
        bus.bg     = '0;
        bus.transp = 1'b0;
        test_reset();
        test_opaque();
        test_reject();
        test_transparent();
        test_back_to_back();
        test_reset_mid_draw();
        test_reset_release();
        test_last_pos();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cell_plotter.md
CELL_PLOTTER -- requirements
Module: cell_plotter

Interface
REQ-001 Parameter CELL_W, default 4, cell width in pixels (fixed; the bench uses the default).
REQ-002 Parameter CELL_H, default 8, cell height in pixels (fixed; the bench uses the default).
REQ-003 Parameter MAX_POS, default 45, number of valid cell positions (0..44).
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; forces reset state immediately, independent of clock.
REQ-006 start  input  1  draw request, sampled each clock edge.
REQ-007 pos_in  input  8  target cell index, sampled with start.
REQ-008 bitmap  input  32  glyph, bit i = pixel (i%4, i/4), sampled with start.
REQ-009 fg  input  3  foreground colour, sampled with start.
REQ-010 bg  input  3  background colour, sampled with start.
REQ-011 transp  input  1  transparent background, sampled with start.
REQ-012 x  output  8  pixel column within cell, feeds the vga stage x input.
REQ-013 y  output  7  pixel row within cell, feeds the vga stage y input.
REQ-014 pos  output  8  latched cell index, feeds the vga stage pos input.
REQ-015 colour  output  3  pixel colour, feeds the vga stage colour input.
REQ-016 plot  output  1  pixel write enable, feeds the vga stage plot input.
REQ-017 busy  output  1  high while a request is in progress.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 err  output  1  one-cycle rejection pulse.

Function
REQ-020 FSM states SHALL be IDLE, DRAW and DONE; all outputs SHALL be registered.
REQ-021 In IDLE, start=1 with pos_in<MAX_POS SHALL latch pos_in, bitmap, fg, bg and transp, clear the 5-bit pixel counter i, and go to DRAW.
REQ-022 In IDLE, start=1 with pos_in>=MAX_POS SHALL pulse err for exactly one cycle, produce no plot, and stay in IDLE.
REQ-023 start SHALL be ignored in DRAW and DONE; latched values SHALL NOT change until the next accepted start.
REQ-024 In DRAW, each cycle SHALL present pixel i: x=i%4 (zero-extended to 8 bits), y=i/4 (zero-extended to 7 bits), pos=latched pos.
REQ-025 In DRAW, colour SHALL be fg when bitmap[i]=1 and bg otherwise.
REQ-026 In DRAW, plot SHALL be 1, except plot SHALL be 0 when transp=1 and bitmap[i]=0.
REQ-027 Pixel order SHALL be row-major, i=0..31, one pixel per cycle, with no stalls.
REQ-028 After i=31, the FSM SHALL go to DONE; DONE SHALL last one cycle with done=1 and plot=0, then return to IDLE.
REQ-029 Timing, for start accepted on edge T: pixel 0 visible after T+1, pixel 31 after T+32, done after T+33; earliest next accepted start is on edge T+34.
REQ-030 busy SHALL be 1 exactly while in DRAW or DONE.
REQ-031 Outside DRAW, plot SHALL be 0; x, y, pos and colour SHALL hold their last values.
REQ-032 The counter SHALL stop at 31 and SHALL NOT wrap into a 33rd plot.

Reset
REQ-033 While reset=1, the FSM SHALL be in IDLE and x=0, y=0, pos=0, colour=0, plot=0, busy=0, done=0, err=0, i=0, and all latched request fields SHALL be 0.
REQ-034 Reset asserted mid-DRAW SHALL abort the sweep with no further plot and no done pulse.
REQ-035 A start coincident with reset deassertion SHALL be accepted only if reset is low at that clock edge.

Verification
REQ-036 start, pos_in=7, bitmap=32'hFFFF0000, fg=3'b100, bg=3'b001, transp=0 -> 32 plot cycles; pixels 0-15 colour=001, pixels 16-31 colour=100; pos=7 throughout; done at T+33.
REQ-037 start, pos_in=45 -> err=1 for one cycle at T+1; plot, busy and done stay 0.
REQ-038 Same as REQ-036 with transp=1 -> plot=1 only for i=16..31 (16 pulses); x/y still step through all 32 pixels.
REQ-039 start repeated every cycle from T -> only the first is accepted; the second is accepted on edge T+34; the pos_in change during busy does not alter the pos output.
REQ-040 Reset asserted at T+10, then a new start -> plot drops immediately; no done pulse; the new request starts cleanly at x=0, y=0.
REQ-041 pos_in=44, bitmap=32'h00000001 -> accepted; the first pixel has x=0, y=0, colour=fg; the last pixel has x=3, y=7.
